gray_ptr_counter: RTL and testbench
===================================

// Module: gray_ptr_counter
// PURPOSE
//   Binary-to-Gray pointer counter: a WIDTH-bit binary up-counter with a registered,
//   glitch-free Gray-coded copy of the count. It is the encode side of the existing
//   gray_binary decoder and produces FIFO/ring pointers that other clock domains sample.
//   Only gray_ptr may cross clock domains. bin_ptr is for local addressing only.
// PARAMETERS
//   WIDTH      4   pointer width in bits (>=2); count range 0 .. 2**WIDTH-1
//   RESET_VAL  0   binary value loaded on reset; gray_ptr resets to its Gray encoding
// PORTS
//   clk        in   1      single clock, rising-edge
//   rst_n      in   1      asynchronous assert, active-low reset
//   clr        in   1      synchronous clear to 0
//   load_en    in   1      synchronous load of load_bin
//   load_bin   in   WIDTH  binary value to load
//   inc_en     in   1      advance pointer by 1
//   bin_ptr    out  WIDTH  registered binary count
//   gray_ptr   out  WIDTH  registered Gray count; always equals bin_ptr ^ (bin_ptr >> 1)
//   bin_next   out  WIDTH  combinational next binary value (for look-ahead full/empty)
//   gray_next  out  WIDTH  combinational Gray encoding of bin_next
//   wrap       out  1      registered one-cycle pulse; pointer rolled over from all-ones to 0
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous):
//     - bin_ptr=RESET_VAL, gray_ptr=RESET_VAL^(RESET_VAL>>1), wrap=0.
//     - Outputs stay at these values while rst_n is low.
//     - Counting resumes on the first clk edge with rst_n=1.
//   - Per-cycle priority is clr > load_en > inc_en > hold:
//     - clr: bin_next=0. wrap=0.
//     - load_en: bin_next=load_bin. wrap=0. Any inc_en in that cycle is ignored.
//     - inc_en: bin_next=bin_ptr+1, modulo 2**WIDTH.
//       wrap=1 next cycle only if bin_ptr was all-ones.
//     - otherwise: bin_next=bin_ptr. wrap=0.
//   - Latency: bin_ptr, gray_ptr and wrap all update on the same edge.
//     One cycle after the qualifying input. No combinational path from inputs to registered outputs.
//   - gray_ptr is flopped directly from gray_next = bin_next ^ (bin_next >> 1).
//     It is never decoded from bin_ptr after the flop, so no glitches reach other domains.
//   - Increment step: gray_ptr changes in exactly one bit, including the rollover
//     (e.g. WIDTH=4: 1000 -> 0000).
//   - clr/load: gray_ptr may change in several bits. Callers do this only while the
//     consuming domain is quiescent.
//   - inc_en held high: one increment per cycle, continuous wrap-around, no saturation.
//     wrap pulses once every 2**WIDTH cycles.
//   - Reset during counting: state aborts immediately to the reset values; no partial update.
//   - X on inc_en, clr or load_en while rst_n=1 is a protocol error. Flag it with a sim-only assertion.
// STRUCTURE
//   - Shared package gray_pkg:
//     - function bin2gray(bin) = bin ^ (bin >> 1)
//     - function gray2bin(gray), the XOR prefix from the MSB, same algorithm as gray_binary
//     - localparam GRAY_W_DEFAULT = 4
//   - One natural sub-module: bin2gray_comb (combinational WIDTH-bit encoder).
//     Instantiate it for gray_next. The bench reuses it in the scoreboard.
//   - Top level: next-state mux, bin/gray/wrap registers, assertions.
// TESTING (WIDTH=4, RESET_VAL=0 unless noted)
//   1. Reset: rst_n=0 mid-cycle -> outputs 0 immediately (async).
//      Release, inc_en=0 for 5 cycles -> bin_ptr=0000, gray_ptr=0000, wrap=0 throughout.
//   2. Count: inc_en=1 for 16 cycles -> gray_ptr sequence
//      0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
//      Exactly one bit flips per step. wrap=1 only on the 1000->0000 cycle.
//   3. Load: load_en=1, load_bin=1010, inc_en=1 -> next cycle bin_ptr=1010, gray_ptr=1111, wrap=0.
//      Then one inc -> bin_ptr=1011, gray_ptr=1110.
//   4. Priority: bin_ptr=1111, clr=1, load_en=1, inc_en=1 -> bin_ptr=0000, gray_ptr=0000, wrap=0.
//   5. Reset mid-run: count to 0110, assert rst_n=0 between edges -> outputs 0000 before the next edge.
//      RESET_VAL=5 build -> bin_ptr=0101, gray_ptr=0111 after reset.
//   6. Closed loop: 1000 random cycles of clr/load/inc.
//      Check gray_binary(gray_ptr)==bin_ptr every cycle.
//      Check gray_next==bin2gray(bin_next) and a one-bit change on every pure increment.

Source files
------------

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared Gray-code helpers for the pointer counter and for anything that has
//   to encode or decode its pointers.
//   - GRAY_W_DEFAULT : default pointer width.
//   - gray_word_t    : widest word the helper functions operate on.
//   - next_src_e     : which rule produces the next pointer value.
//   - bin2gray()     : bin ^ (bin >> 1).
//   - gray2bin()     : XOR prefix from the MSB down, the same algorithm as the
//                      gray_binary decoder.
//   The functions are written for a full gray_word_t. Narrower pointers are
//   zero-extended on the way in and truncated on the way out. Zero upper bits
//   decode to zero, so the result is exact for any width up to GRAY_W_MAX.
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  typedef logic [GRAY_W_MAX-1:0] gray_word_t;

  // Winning term of the clr > load_en > inc_en > hold priority.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_INC  = 2'd1,
    SRC_LOAD = 2'd2,
    SRC_CLR  = 2'd3
  } next_src_e;

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_W_MAX-1] = gray[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_counter_if.sv
// -----------------------------------------------------------------------------
// gray_ptr_counter_if
//   Control and pointer bundle for gray_ptr_counter.
//   Signals:
//     clr        ctrl  1      synchronous clear to 0
//     load_en    ctrl  1      synchronous load of load_bin
//     load_bin   ctrl  WIDTH  binary value to load
//     inc_en     ctrl  1      advance pointer by 1
//     bin_ptr    ptr   WIDTH  registered binary count (local addressing only)
//     gray_ptr   ptr   WIDTH  registered Gray count (the only signal that may
//                             cross clock domains)
//     bin_next   ptr   WIDTH  combinational next binary value
//     gray_next  ptr   WIDTH  combinational Gray encoding of bin_next
//     wrap       ptr   1      registered one-cycle rollover pulse
//   Modports:
//     master : drives the control signals and observes the pointers.
//     slave  : the counter itself.
// -----------------------------------------------------------------------------
interface gray_ptr_counter_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
);

  logic             clr;
  logic             load_en;
  logic [WIDTH-1:0] load_bin;
  logic             inc_en;
  logic [WIDTH-1:0] bin_ptr;
  logic [WIDTH-1:0] gray_ptr;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap;

  modport master (
    output clr, load_en, load_bin, inc_en,
    input  bin_ptr, gray_ptr, bin_next, gray_next, wrap
  );

  modport slave (
    input  clr, load_en, load_bin, inc_en,
    output bin_ptr, gray_ptr, bin_next, gray_next, wrap
  );

endinterface

// File: rtl/bin2gray_comb.sv
// -----------------------------------------------------------------------------
// bin2gray_comb
//   Purely combinational WIDTH-bit binary-to-Gray encoder.
//   Ports:
//     bin   in   WIDTH  binary value
//     gray  out  WIDTH  bin ^ (bin >> 1)
// -----------------------------------------------------------------------------
module bin2gray_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_ptr_counter.sv
// -----------------------------------------------------------------------------
// gray_ptr_counter
//   WIDTH-bit binary up-counter with a registered, glitch-free Gray copy of the
//   count, used as a FIFO/ring pointer that other clock domains sample.
//   Ports:
//     clk    in  1   rising-edge clock
//     rst_n  in  1   asynchronous, active-low reset (loads RESET_VAL)
//     bus    gray_ptr_counter_if.slave
//       controls: clr, load_en, load_bin, inc_en
//       outputs : bin_ptr, gray_ptr, wrap (registered)
//                 bin_next, gray_next (combinational look-ahead)
//   Parameters:
//     WIDTH      pointer width (>= 2)
//     RESET_VAL  binary value loaded on reset
//   The Gray register is loaded from gray_next, the encoding of the next binary
//   value. It is never re-derived from bin_ptr after the flop. This means
//   gray_ptr comes straight from a flop and carries no decode glitches into the
//   sampling domain.
// -----------------------------------------------------------------------------
module gray_ptr_counter
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_W_DEFAULT,
  parameter int RESET_VAL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_ptr_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  next_src_e        src;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  // Next-state selection: clr > load_en > inc_en > hold.
  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    src      = SRC_HOLD;
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;

    if (bus.clr) begin
      src = SRC_CLR;
    end else if (bus.load_en) begin
      src = SRC_LOAD;
    end else if (bus.inc_en) begin
      src = SRC_INC;
    end

    case (src)
      SRC_CLR:  bin_nxt = '0;
      SRC_LOAD: bin_nxt = bus.load_bin;
      SRC_INC: begin
        bin_nxt  = bin_q + ONE;  // natural modulo 2**WIDTH rollover
        wrap_nxt = (bin_q == '1);
      end
      default:  bin_nxt = bin_q;
    endcase
  end

  bin2gray_comb #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // bin, gray and wrap all change on the same edge.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RESET_BIN;
      gray_q <= RESET_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.bin_ptr   = bin_q;
  assign bus.gray_ptr  = gray_q;
  assign bus.wrap      = wrap_q;
  assign bus.bin_next  = bin_nxt;
  assign bus.gray_next = gray_nxt;

`ifndef SYNTHESIS
  // Unknown control inputs outside reset are a protocol error by the caller.
  a_ctrl_known: assert property (
    @(posedge clk) disable iff (!rst_n)
      !$isunknown({bus.clr, bus.load_en, bus.inc_en})
  ) else $error("gray_ptr_counter: X on clr/load_en/inc_en");

  // The Gray register must always be the encoding of the binary register.
  a_gray_tracks_bin: assert property (
    @(posedge clk) disable iff (!rst_n)
      gray_q == WIDTH'(bin2gray(gray_word_t'(bin_q)))
  ) else $error("gray_ptr_counter: gray_ptr out of step with bin_ptr");
`endif

endmodule

// File: tb/tb_gray_ptr_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_ptr_counter
//   Self-checking bench for gray_ptr_counter (WIDTH=4).
//   The stimulus process drives one cycle at a time from the falling edge. It
//   checks the combinational look-ahead outputs and pushes the expected
//   registered state into a queue. A separate monitor pops one entry after each
//   rising edge and compares it with the registered outputs.
//   A second instance built with RESET_VAL=5 shares the controls. It is used
//   only to check the reset value.
// -----------------------------------------------------------------------------
module tb_gray_ptr_counter;
  import gray_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         pure_inc;
    logic [W-1:0] prev_gray;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  gray_ptr_counter_if #(.WIDTH(W)) bus ();
  gray_ptr_counter_if #(.WIDTH(W)) bus5 ();

  assign bus5.clr      = bus.clr;
  assign bus5.load_en  = bus.load_en;
  assign bus5.load_bin = bus.load_bin;
  assign bus5.inc_en   = bus.inc_en;

  gray_ptr_counter #(.WIDTH(W), .RESET_VAL(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  gray_ptr_counter #(.WIDTH(W), .RESET_VAL(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  logic [W-1:0] ref_gray;
  bin2gray_comb #(.WIDTH(W)) u_ref_enc (
    .bin  (bus.bin_next),
    .gray (ref_gray)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   model_bin;  // reference pointer value, plain integer 0..15

  logic [W-1:0] gseq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100,
                              4'b1101, 4'b1111, 4'b1110, 4'b1010,
                              4'b1011, 4'b1001, 4'b1000, 4'b0000};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b / 2);
  endfunction

  // One clock cycle, entered and left on a falling edge.
  task automatic do_cycle(input logic c, input logic l, input logic [W-1:0] lb,
                          input logic i);
    int   nb;
    logic nw;
    exp_t e;
    bus.clr      = c;
    bus.load_en  = l;
    bus.load_bin = lb;
    bus.inc_en   = i;
    #1;
    if (c)      nb = 0;
    else if (l) nb = int'(lb);
    else if (i) nb = (model_bin + 1) % 16;
    else        nb = model_bin;
    nw = !c && !l && i && (model_bin == 15);
    check("bin_next",      32'(bus.bin_next),  32'(nb));
    check("gray_next",     32'(bus.gray_next), 32'(to_gray(nb)));
    check("gray_next_enc", 32'(bus.gray_next), 32'(ref_gray));
    e.bin       = W'(nb);
    e.gray      = W'(to_gray(nb));
    e.wrap      = nw;
    e.pure_inc  = !c && !l && i;
    e.prev_gray = bus.gray_ptr;
    exp_q.push_back(e);
    model_bin = nb;
    @(negedge clk);
  endtask

  // Monitor: one expected entry per rising edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("bin_ptr",   32'(bus.bin_ptr),  32'(e.bin));
        check("gray_ptr",  32'(bus.gray_ptr), 32'(e.gray));
        check("wrap",      32'(bus.wrap),     32'(e.wrap));
        check("gray_decode", gray2bin(gray_word_t'(bus.gray_ptr)),
              32'(bus.bin_ptr));
        if (e.pure_inc)
          check("one_bit_step",
                32'($countones(bus.gray_ptr ^ e.prev_gray)), 32'd1);
      end
    end
  end

  // Watchdog: the run is a little over 1000 cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b1;
    bus.clr      = 1'b0;
    bus.load_en  = 1'b0;
    bus.load_bin = '0;
    bus.inc_en   = 1'b0;
    model_bin    = 0;

    // 1. Asynchronous reset mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_bin",  32'(bus.bin_ptr),   32'h0);
    check("rst_async_gray", 32'(bus.gray_ptr),  32'h0);
    check("rst_async_wrap", 32'(bus.wrap),      32'h0);
    check("rst5_bin",       32'(bus5.bin_ptr),  32'h5);
    check("rst5_gray",      32'(bus5.gray_ptr), 32'h7);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_bin",   32'(bus.bin_ptr),   32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b0, 1'b0, 4'h0, 1'b0);
      check("idle_wrap", 32'(bus.wrap), 32'h0);
    end
    check("rst5_after_bin", 32'(bus5.bin_ptr), 32'h5);

    // 2. Sixteen increments: full Gray sequence, wrap only on the last.
    for (int k = 0; k < 16; k++) begin
      do_cycle(1'b0, 1'b0, 4'h0, 1'b1);
      check("gray_seq",  32'(bus.gray_ptr), 32'(gseq[k]));
      check("wrap_seq",  32'(bus.wrap),     32'(k == 15));
    end

    // 3. Load beats a simultaneous increment.
    do_cycle(1'b0, 1'b1, 4'b1010, 1'b1);
    check("load_bin",  32'(bus.bin_ptr),  32'b1010);
    check("load_gray", 32'(bus.gray_ptr), 32'b1111);
    do_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check("inc_after_load_bin",  32'(bus.bin_ptr),  32'b1011);
    check("inc_after_load_gray", 32'(bus.gray_ptr), 32'b1110);

    // 4. Rollover from a loaded all-ones, then clr beats load and inc.
    do_cycle(1'b0, 1'b1, 4'hF, 1'b0);
    do_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check("roll_wrap", 32'(bus.wrap), 32'h1);
    do_cycle(1'b0, 1'b1, 4'hF, 1'b0);
    check("load_f_wrap", 32'(bus.wrap), 32'h0);
    do_cycle(1'b1, 1'b1, 4'h9, 1'b1);
    check("prio_bin",  32'(bus.bin_ptr),  32'h0);
    check("prio_gray", 32'(bus.gray_ptr), 32'h0);
    check("prio_wrap", 32'(bus.wrap),     32'h0);

    // 5. Count to 0110, then reset between edges.
    for (int k = 0; k < 6; k++) do_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check("pre_rst_bin", 32'(bus.bin_ptr), 32'b0110);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_bin",  32'(bus.bin_ptr),   32'h0);
    check("midrun_rst_gray", 32'(bus.gray_ptr),  32'h0);
    check("midrun_rst5_bin", 32'(bus5.bin_ptr),  32'h5);
    check("midrun_rst5_gray",32'(bus5.gray_ptr), 32'h7);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    model_bin = 0;
    do_cycle(1'b0, 1'b0, 4'h0, 1'b0);
    check("post_rst5_gray", 32'(bus5.gray_ptr), 32'h7);

    // 6. Closed-loop random run.
    for (int k = 0; k < 1000; k++) begin
      logic c, l, i;
      logic [W-1:0] lb;
      c  = ($urandom_range(0, 99) < 4);
      l  = ($urandom_range(0, 99) < 10);
      i  = ($urandom_range(0, 99) < 75);
      lb = W'($urandom_range(0, 15));
      do_cycle(c, l, lb, i);
    end

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
